// File: rtl/regfile_write_buffer.sv
// In-order write buffer in front of a register file write port. Requests are
// queued and drained one per cycle, and pending writes are forwarded to two readers.
module regfile_write_buffer #(
  parameter int WIDTH    = 32,
  parameter int ADDRBITS = 5,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRBITS-1:0]      in_addr,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     drain_en,
  output logic                     out_wrenable,
  output logic [ADDRBITS-1:0]      out_addr,
  output logic [WIDTH-1:0]         out_data,
  input  logic [ADDRBITS-1:0]      raddr1,
  input  logic [ADDRBITS-1:0]      raddr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [WIDTH-1:0]         fwd_data1,
  output logic [WIDTH-1:0]         fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [ADDRBITS-1:0] r_addr_mem [DEPTH];
  logic [WIDTH-1:0]    r_data_mem [DEPTH];
  logic [PTRW-1:0]     r_wptr;
  logic [PTRW-1:0]     r_rptr;
  logic [CNTW-1:0]     r_count;

  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [WIDTH:0]      w_fwd1;
  logic [WIDTH:0]      w_fwd2;

  assign w_empty      = (r_count == '0);
  assign in_ready     = (r_count < CNTW'(DEPTH));
  // Writes to register 0 complete the handshake but are never stored.
  assign w_push       = in_valid && in_ready && (in_addr != '0);
  assign out_wrenable = !w_empty && drain_en;
  assign w_pop        = out_wrenable;
  assign out_addr     = w_empty ? '0 : r_addr_mem[r_rptr];
  assign out_data     = w_empty ? '0 : r_data_mem[r_rptr];
  assign count        = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= in_addr;
      r_data_mem[r_wptr] <= in_data;
    end
  end

  // Walk entries oldest to youngest so the last match (youngest) wins.
  function automatic logic [WIDTH:0] fwd_lookup(input logic [ADDRBITS-1:0] raddr);
    logic [WIDTH:0]  res;
    logic [PTRW-1:0] idx;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rptr + PTRW'(k);
      if ((raddr != '0) && (CNTW'(k) < r_count) && (r_addr_mem[idx] == raddr))
        res = {1'b1, r_data_mem[idx]};
    end
    return res;
  endfunction

  always_comb begin
    w_fwd1 = fwd_lookup(raddr1);
    w_fwd2 = fwd_lookup(raddr2);
  end

  assign fwd_hit1  = w_fwd1[WIDTH];
  assign fwd_data1 = w_fwd1[WIDTH-1:0];
  assign fwd_hit2  = w_fwd2[WIDTH];
  assign fwd_data2 = w_fwd2[WIDTH-1:0];

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer: inputs change on the falling edge,
// outputs are checked just after, before the next rising edge.
module tb_regfile_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        out_wrenable;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_write_buffer #(.WIDTH(32), .ADDRBITS(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en),
    .out_wrenable(out_wrenable), .out_addr(out_addr), .out_data(out_data),
    .raddr1(raddr1), .raddr2(raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  // Advance to the next falling edge; settle briefly before checks.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b0; raddr1 = 5'd5; raddr2 = 5'd0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    total++;
    if (count !== 3'd0 || in_ready !== 1'b1 || out_wrenable !== 1'b0 || fwd_hit1 !== 1'b0) begin
      bad++;
      $display("FAIL reset: count=%0d ready=%b wren=%b hit1=%b required 0 1 0 0",
               count, in_ready, out_wrenable, fwd_hit1);
    end
    $display("reset: count=%0d ready=%b wren=%b", count, in_ready, out_wrenable);
  endtask

  task automatic test_single_write();
    drain_en = 1'b1;
    drive(1'b1, 5'd3, 32'hDEADBEEF);
    step();
    drive(1'b0, 5'd0, 32'h0);
    total++;
    if (out_wrenable !== 1'b1 || out_addr !== 5'd3 || out_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_out: wren=%b addr=%0d data=%h required 1 3 deadbeef",
               out_wrenable, out_addr, out_data);
    end
    $display("single write: wren=%b addr=%0d data=%h", out_wrenable, out_addr, out_data);
    step();
    total++;
    if (count !== 3'd0 || out_wrenable !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: count=%0d wren=%b required 0 0", count, out_wrenable);
    end
  endtask

  task automatic test_fill_stall();
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'(i * 32'h11));
      step();
    end
    total++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_full: count=%0d ready=%b required 4 0", count, in_ready);
    end
    drive(1'b1, 5'd5, 32'h55);
    step();
    drive(1'b0, 5'd0, 32'h0);
    total++;
    if (count !== 3'd4 || out_addr !== 5'd1) begin
      bad++;
      $display("FAIL fill_fifth: count=%0d head=%0d required 4 1", count, out_addr);
    end
    drain_en = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (out_wrenable !== 1'b1 || out_addr !== 5'(i) || out_data !== 32'(i * 32'h11)) begin
        bad++;
        $display("FAIL fill_drain%0d: wren=%b addr=%0d data=%h required 1 %0d %h",
                 i, out_wrenable, out_addr, out_data, i, i * 32'h11);
      end
      $display("drain: addr=%0d data=%h", out_addr, out_data);
      if (i == 1) begin
        step();
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL ready_after_pop: ready=%b required 1", in_ready);
        end
      end else begin
        step();
      end
    end
    total++;
    if (count !== 3'd0 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL fill_empty: count=%0d data=%h required 0 0", count, out_data);
    end
  endtask

  task automatic test_forwarding();
    drain_en = 1'b0;
    drive(1'b1, 5'd7, 32'hA);
    step();
    drive(1'b1, 5'd7, 32'hB);
    step();
    drive(1'b0, 5'd0, 32'h0);
    raddr1 = 5'd7; raddr2 = 5'd0;
    #1;
    total++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hB || fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin
      bad++;
      $display("FAIL fwd_youngest: hit1=%b data1=%h hit2=%b data2=%h required 1 b 0 0",
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    end
    $display("forward: hit1=%b data1=%h hit2=%b", fwd_hit1, fwd_data1, fwd_hit2);
    raddr2 = 5'd9;
    #1;
    total++;
    if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin
      bad++;
      $display("FAIL fwd_miss: hit2=%b data2=%h required 0 0", fwd_hit2, fwd_data2);
    end
  endtask

  task automatic test_zero_and_simul();
    drive(1'b1, 5'd0, 32'hFF);
    step();
    drive(1'b0, 5'd0, 32'h0);
    total++;
    if (count !== 3'd2 || out_addr !== 5'd7 || out_data !== 32'hA) begin
      bad++;
      $display("FAIL zero_addr: count=%0d head=%0d/%h required 2 7/a", count, out_addr, out_data);
    end
    $display("zero addr: count=%0d", count);
    drain_en = 1'b1;
    drive(1'b1, 5'd9, 32'hC);
    total++;
    if (out_wrenable !== 1'b1 || out_data !== 32'hA || fwd_hit2 !== 1'b0) begin
      bad++;
      $display("FAIL simul_same: wren=%b data=%h hit2=%b required 1 a 0",
               out_wrenable, out_data, fwd_hit2);
    end
    step();
    drive(1'b0, 5'd0, 32'h0);
    total++;
    if (count !== 3'd2 || out_addr !== 5'd7 || out_data !== 32'hB ||
        fwd_hit2 !== 1'b1 || fwd_data2 !== 32'hC) begin
      bad++;
      $display("FAIL simul_after: count=%0d head=%0d/%h hit2=%b data2=%h required 2 7/b 1 c",
               count, out_addr, out_data, fwd_hit2, fwd_data2);
    end
    $display("push+pop: count=%0d head=%0d/%h", count, out_addr, out_data);
    step();
    total++;
    if (out_addr !== 5'd9 || out_data !== 32'hC || fwd_hit1 !== 1'b0) begin
      bad++;
      $display("FAIL simul_order: head=%0d/%h hit1=%b required 9/c 0", out_addr, out_data, fwd_hit1);
    end
    step();
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL simul_empty: count=%0d required 0", count);
    end
  endtask

  task automatic test_reset_mid();
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(10 + i), 32'(32'h100 + i));
      step();
    end
    drive(1'b0, 5'd0, 32'h0);
    drain_en = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || out_wrenable !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: count=%0d wren=%b required 0 0", count, out_wrenable);
    end
    $display("reset mid: count=%0d wren=%b", count, out_wrenable);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_wrenable !== 1'b0) begin
        bad++;
        $display("FAIL reset_nowrite%0d: wren=%b required 0", i, out_wrenable);
      end
    end
    drive(1'b1, 5'd4, 32'h44);
    step();
    drive(1'b0, 5'd0, 32'h0);
    total++;
    if (out_wrenable !== 1'b1 || out_addr !== 5'd4 || out_data !== 32'h44) begin
      bad++;
      $display("FAIL reset_first: wren=%b addr=%0d data=%h required 1 4 44",
               out_wrenable, out_addr, out_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_stall();
    test_forwarding();
    test_zero_and_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
